msg_chunk_deserializer: RTL and testbench

- Upstream stage of the parallel RCE encoder: packs the serial message stream (msg qualified by datavalid) into LMLA-bit chunks for the encoding units.
- Double-buffered: one shift register fills while the holding register waits for the encoder to accept the previous chunk.
- Tags each chunk with its index within the K-bit frame and flags the last chunk, so the encoder can load parity on frame end.

---
 rtl/rce_enc_pkg.sv | 21 ++
 rtl/chunk_hold_reg.sv | 55 +++++
 rtl/msg_chunk_deserializer.sv | 175 +++++++++++++++++
 tb/tb_msg_chunk_deserializer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rce_enc_pkg.sv
// Shared constants, state encoding and width helper for the RCE encoder front end.
// Frame geometry: K message bits per frame, LMLA bits per chunk.
package rce_enc_pkg;

    localparam int K         = 1024;
    localparam int LMLA      = 256;
    localparam int CIDX_BITS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PEND = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/chunk_hold_reg.sv
// Output holding register: one chunk plus its frame index and last tag,
// held stable until the encoder takes it with valid && ready.
module chunk_hold_reg
    import rce_enc_pkg::*;
#(
    parameter int LMLA      = 256,
    parameter int CIDX_BITS = 2,
    parameter int NCHUNK    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [LMLA-1:0]      data_i,
    input  logic [CIDX_BITS-1:0] idx_i,
    input  logic                 ready_i,
    output logic [LMLA-1:0]      data_o,
    output logic [CIDX_BITS-1:0] idx_o,
    output logic                 last_o,
    output logic                 valid_o,
    output logic                 accept_o
);

    localparam logic [CIDX_BITS-1:0] IDX_LAST = CIDX_BITS'(NCHUNK - 1);

    logic [LMLA-1:0]      data_q;
    logic [CIDX_BITS-1:0] idx_q;
    logic                 last_q;
    logic                 valid_q;

    // Free when empty or when the held chunk leaves this cycle.
    assign accept_o = !valid_q || ready_i;

    // Load wins over drain so a transfer plus load keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            idx_q   <= idx_i;
            last_q  <= (idx_i == IDX_LAST);
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign idx_o   = idx_q;
    assign last_o  = last_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/msg_chunk_deserializer.sv
// Serial-to-chunk packer feeding the parallel RCE encoder, with one pending slot.
// Optional MSG_CHUNK_FLUSH_EN adds a flush input that zero-pads the rest of the frame.
module msg_chunk_deserializer
    import rce_enc_pkg::*;
#(
    parameter int K         = rce_enc_pkg::K,
    parameter int LMLA      = rce_enc_pkg::LMLA,
    parameter int CIDX_BITS = rce_enc_pkg::CIDX_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 msg,
    input  logic                 datavalid,
`ifdef MSG_CHUNK_FLUSH_EN
    input  logic                 flush,
`endif
    output logic [LMLA-1:0]      chunk,
    output logic                 chunk_valid,
    input  logic                 chunk_ready,
    output logic [CIDX_BITS-1:0] chunk_idx,
    output logic                 chunk_last,
    output logic                 frame_busy,
    output logic                 overflow
);

    localparam int NCHUNK = K / LMLA;
    localparam int BC_W   = clog2(LMLA);
    localparam logic [CIDX_BITS-1:0] CIDX_LAST = CIDX_BITS'(NCHUNK - 1);

    state_t               state_q, state_d;
    logic [LMLA-2:0]      shift_q, shift_d;
    logic [BC_W-1:0]      bitcnt_q, bitcnt_d;
    logic [CIDX_BITS-1:0] cidx_q, cidx_d;
    logic                 pend_q, pend_d;
    logic [LMLA-1:0]      pend_data_q, pend_data_d;
    logic [CIDX_BITS-1:0] pend_idx_q, pend_idx_d;
    logic                 ovf_q, ovf_d;

    logic                 in_frame, take, last_bit, done, frame_end;
    logic                 draining, flush_start, drain;
    logic [LMLA-1:0]      shift_in, done_data;
    logic                 load, accept;
    logic [LMLA-1:0]      load_data;
    logic [CIDX_BITS-1:0] load_idx;

    assign in_frame  = (state_q != IDLE);
    assign take      = datavalid && !draining;
    assign shift_in  = {shift_q, msg};
    assign last_bit  = take && in_frame && (&bitcnt_q);
    assign done      = last_bit || flush_start || drain;
    assign frame_end = done && (cidx_q == CIDX_LAST);

`ifdef MSG_CHUNK_FLUSH_EN
    logic            flush_q;
    logic [BC_W:0]   fill_cnt;
    logic [LMLA-1:0] pad_src;

    assign draining    = flush_q;
    assign fill_cnt    = {1'b0, bitcnt_q} + {{BC_W{1'b0}}, take};
    assign pad_src     = take ? shift_in : {1'b0, shift_q};
    assign flush_start = flush && in_frame && !flush_q;
    assign drain       = flush_q && !pend_q;
    assign done_data   = flush_start
                       ? pad_src << ((BC_W+1)'(LMLA) - fill_cnt)
                       : (drain ? '0 : shift_in);

    // Drain mode: emit zero chunks until the frame index wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q <= 1'b0;
        end else if (frame_end) begin
            flush_q <= 1'b0;
        end else if (flush_start) begin
            flush_q <= 1'b1;
        end
    end
`else
    assign draining    = 1'b0;
    assign flush_start = 1'b0;
    assign drain       = 1'b0;
    assign done_data   = shift_in;
`endif

    // Next state: shifting, counters, pending slot and overflow.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        cidx_d      = cidx_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_idx_d  = pend_idx_q;
        ovf_d       = ovf_q;
        load        = 1'b0;
        load_data   = pend_data_q;
        load_idx    = pend_idx_q;

        if (take) begin
            shift_d  = shift_in[LMLA-2:0];
            bitcnt_d = bitcnt_q + 1'b1;
            if (state_q == IDLE) state_d = FILL;
        end

        if (done) begin
            bitcnt_d = '0;
            cidx_d   = cidx_q + 1'b1;
            if (frame_end) state_d = IDLE;
        end

        // Pending chunk is older, so it always goes to holding first.
        if (pend_q && accept) begin
            load        = 1'b1;
            pend_d      = done;
            pend_data_d = done_data;
            pend_idx_d  = cidx_q;
        end else if (done && accept) begin
            load      = 1'b1;
            load_data = done_data;
            load_idx  = cidx_q;
        end else if (done && !pend_q) begin
            pend_d      = 1'b1;
            pend_data_d = done_data;
            pend_idx_d  = cidx_q;
        end else if (done) begin
            ovf_d = 1'b1;
        end

        if (state_d != IDLE) state_d = pend_d ? PEND : FILL;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            cidx_q      <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_idx_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            cidx_q      <= cidx_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_idx_q  <= pend_idx_d;
            ovf_q       <= ovf_d;
        end
    end

    chunk_hold_reg #(
        .LMLA      (LMLA),
        .CIDX_BITS (CIDX_BITS),
        .NCHUNK    (NCHUNK)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .data_i   (load_data),
        .idx_i    (load_idx),
        .ready_i  (chunk_ready),
        .data_o   (chunk),
        .idx_o    (chunk_idx),
        .last_o   (chunk_last),
        .valid_o  (chunk_valid),
        .accept_o (accept)
    );

    assign frame_busy = in_frame;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_msg_chunk_deserializer.sv
// Scoreboard bench for msg_chunk_deserializer; covers flush when
// MSG_CHUNK_FLUSH_EN is defined.
module tb_msg_chunk_deserializer;

    localparam int LMLA = 256;

    typedef struct packed {
        logic [LMLA-1:0] data;
        logic [1:0]      idx;
        logic            last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            msg = 1'b0;
    logic            datavalid = 1'b0;
    logic            flush = 1'b0;
    logic [LMLA-1:0] chunk;
    logic            chunk_valid;
    logic            chunk_ready = 1'b1;
    logic [1:0]      chunk_idx;
    logic            chunk_last;
    logic            frame_busy;
    logic            overflow;

    int checks = 0;
    int failures = 0;

    exp_t            exp_q[$];
    logic [LMLA-1:0] m_shift = '0;
    int              m_cnt = 0;
    int              m_idx = 0;

    always #5 clk = ~clk;

    msg_chunk_deserializer dut (
        .clk         (clk),
        .rst         (rst),
        .msg         (msg),
        .datavalid   (datavalid),
`ifdef MSG_CHUNK_FLUSH_EN
        .flush       (flush),
`endif
        .chunk       (chunk),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_idx   (chunk_idx),
        .chunk_last  (chunk_last),
        .frame_busy  (frame_busy),
        .overflow    (overflow)
    );

    task automatic push_exp(input logic [LMLA-1:0] d);
        exp_t e;
        e.data = d;
        e.idx  = 2'(m_idx);
        e.last = (m_idx == 3);
        exp_q.push_back(e);
        m_idx = (m_idx + 1) % 4;
    endtask

    task automatic model_bit(input logic b);
        m_shift = {m_shift[LMLA-2:0], b};
        m_cnt++;
        if (m_cnt == LMLA) begin
            push_exp(m_shift);
            m_cnt = 0;
        end
    endtask

    task automatic model_reset();
        m_shift = '0;
        m_cnt = 0;
        m_idx = 0;
        exp_q.delete();
    endtask

    task automatic step(input logic dv, input logic b);
        datavalid = dv;
        msg = b;
        @(posedge clk);
        #1;
        if (dv) model_bit(b);
    endtask

    function automatic logic pat(input int i);
        return (i % 3 == 0);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && chunk_valid && chunk_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL xfer_unexpected got idx=%0d", chunk_idx);
            end else begin
                e = exp_q.pop_front();
                if (chunk !== e.data || chunk_idx !== e.idx
                    || chunk_last !== e.last) begin
                    failures++;
                    $display("FAIL xfer got idx=%0d last=%0b data=%h want idx=%0d last=%0b data=%h",
                             chunk_idx, chunk_last, chunk, e.idx, e.last, e.data);
                end
            end
        end
    end

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s pending_chunks got %0d want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (chunk !== '0 || chunk_valid !== 1'b0 || chunk_idx !== 2'd0
            || chunk_last !== 1'b0 || frame_busy !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%0b idx=%0d last=%0b busy=%0b ovf=%0b want all 0",
                     chunk_valid, chunk_idx, chunk_last, frame_busy, overflow);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        chunk_ready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, pat(i));
            if (i % 256 == 254) begin
                checks++;
                if (chunk_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_early_valid bit=%0d got %0b want 0", i, chunk_valid);
                end
            end
            if (i % 256 == 255) begin
                checks++;
                if (chunk_valid !== 1'b1 || chunk_idx !== 2'(i / 256)
                    || chunk[LMLA-1] !== pat(i - 255)
                    || chunk_last !== (i == 1023) || overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_chunk bit=%0d got v=%0b idx=%0d msb=%0b last=%0b ovf=%0b want v=1 idx=%0d msb=%0b last=%0b ovf=0",
                             i, chunk_valid, chunk_idx, chunk[LMLA-1], chunk_last, overflow,
                             i / 256, pat(i - 255), i == 1023);
                end
            end
            if (i == 600) begin
                checks++;
                if (frame_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_busy got %0b want 1", frame_busy);
                end
            end
        end
        checks++;
        if (frame_busy !== 1'b0) begin
            failures++;
            $display("FAIL stream_busy_end got %0b want 0", frame_busy);
        end
        step(1'b0, 1'b0);
        check_queue_empty("stream");
    endtask

    task automatic test_gaps();
        chunk_ready = 1'b1;
        for (int j = 0; j < 2048; j++) begin
            step(j % 2 == 0, pat(j / 2));
            if (j % 512 == 509 || j % 512 == 510) begin
                checks++;
                if (chunk_valid !== (j % 512 == 510)) begin
                    failures++;
                    $display("FAIL gaps_valid step=%0d got %0b want %0b",
                             j, chunk_valid, j % 512 == 510);
                end
            end
        end
        step(1'b0, 1'b0);
        check_queue_empty("gaps");
    endtask

    task automatic test_stall();
        chunk_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            if (i == 556) chunk_ready = 1'b1;
            step(1'b1, pat(i));
            if (i == 511 || i == 555) begin
                checks++;
                if (chunk_valid !== 1'b1 || chunk_idx !== 2'd0
                    || chunk !== exp_q[0].data || overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold bit=%0d got v=%0b idx=%0d ovf=%0b data=%h want v=1 idx=0 ovf=0 data=%h",
                             i, chunk_valid, chunk_idx, overflow, chunk, exp_q[0].data);
                end
            end
            if (i == 556) begin
                checks++;
                if (chunk_valid !== 1'b1 || chunk_idx !== 2'd1) begin
                    failures++;
                    $display("FAIL stall_b2b got v=%0b idx=%0d want v=1 idx=1",
                             chunk_valid, chunk_idx);
                end
            end
        end
        step(1'b0, 1'b0);
        check_queue_empty("stall");
    endtask

    task automatic test_overflow();
        chunk_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, pat(i + 1));
            if (i == 766 || i == 767) begin
                checks++;
                if (overflow !== (i == 767)) begin
                    failures++;
                    $display("FAIL ovf_set bit=%0d got %0b want %0b", i, overflow, i == 767);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || chunk_idx !== 2'd0 || chunk !== exp_q[0].data
            || frame_busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_hold got ovf=%0b idx=%0d busy=%0b data=%h want ovf=1 idx=0 busy=0 data=%h",
                     overflow, chunk_idx, frame_busy, chunk, exp_q[0].data);
        end
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        chunk_ready = 1'b1;
        repeat (4) step(1'b0, 1'b0);
        check_queue_empty("ovf");
        checks++;
        if (overflow !== 1'b1 || chunk_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sticky got ovf=%0b v=%0b want ovf=1 v=0", overflow, chunk_valid);
        end
    endtask

    task automatic test_reset_midframe();
        chunk_ready = 1'b1;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (chunk !== '0 || chunk_valid !== 1'b0 || chunk_idx !== 2'd0
            || chunk_last !== 1'b0 || frame_busy !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got v=%0b idx=%0d last=%0b busy=%0b ovf=%0b data=%h want all 0",
                     chunk_valid, chunk_idx, chunk_last, frame_busy, overflow, chunk);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) step(1'b1, pat(i + 2));
        step(1'b0, 1'b0);
        check_queue_empty("reset_frame");
    endtask

`ifdef MSG_CHUNK_FLUSH_EN
    task automatic test_flush();
        logic [LMLA-1:0] pad;
        chunk_ready = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        pad = {{(LMLA-10){1'b0}}, 10'h3FF} << 246;
        push_exp(pad);
        push_exp('0);
        push_exp('0);
        push_exp('0);
        m_cnt = 0;
        flush = 1'b1;
        step(1'b0, 1'b0);
        flush = 1'b0;
        checks++;
        if (chunk_valid !== 1'b1 || chunk !== pad) begin
            failures++;
            $display("FAIL flush_pad got v=%0b data=%h want v=1 data=%h", chunk_valid, chunk, pad);
        end
        repeat (8) step(1'b0, 1'b0);
        check_queue_empty("flush");
        checks++;
        if (frame_busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy got %0b want 0", frame_busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_stall();
        test_overflow();
        test_reset_midframe();
`ifdef MSG_CHUNK_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
